// File: rtl/dpll_pkg.sv
// Shared types and constants for the oscillator-trim DAC write path.
// The clamp bounds and helper are used only when DAC_CLAMP_EN is defined.
package dpll_pkg;

  localparam int DAC_W = 16;

  localparam logic [DAC_W-1:0] RESET_CODE_DEF = 16'h9E23;
  localparam logic [DAC_W-1:0] DAC_MIN        = 16'h0400;
  localparam logic [DAC_W-1:0] DAC_MAX        = 16'hFBFF;

  localparam logic SRC_LOOP = 1'b0;
  localparam logic SRC_HOST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_MSB,
    ST_ARM1,
    ST_SEND_LSB,
    ST_ARM2,
    ST_DRAIN,
    ST_GAP
  } state_t;

  function automatic logic [DAC_W-1:0] clamp_code(input logic [DAC_W-1:0] c);
    logic [DAC_W-1:0] r;
    r = c;
    if (c < DAC_MIN) r = DAC_MIN;
    else if (c > DAC_MAX) r = DAC_MAX;
    return r;
  endfunction

endpackage

// File: rtl/dac_rr_grant.sv
// Two-way round-robin selector between loop and host DAC requests.
// While hold is set, a loop request is reported as a drop and is never granted.
module dac_rr_grant
  import dpll_pkg::*;
(
  input  logic loop_req,
  input  logic host_req,
  input  logic hold,
  input  logic last_src,
  output logic grant_valid,
  output logic grant_src,
  output logic drop
);

  logic loop_ok;

  always_comb begin
    loop_ok     = loop_req & ~hold;
    drop        = loop_req & hold;
    grant_valid = loop_ok | host_req;
    // With both eligible, the source that did not win last time goes first.
    if (loop_ok && host_req) grant_src = ~last_src;
    else if (host_req)       grant_src = SRC_HOST;
    else                     grant_src = SRC_LOOP;
  end

endmodule

// File: rtl/dac_write_arbiter.sv
// Arbitrates loop and host writes to the SPI trim DAC: two-byte frames, settle gap, timeout abort.
// Define DAC_CLAMP_EN to clamp granted codes to [DAC_MIN, DAC_MAX] before they are sent.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | drop held-off loop requests, grant an eligible request
// SEND_MSB  | wait for ready, strobe the high byte
// ARM1      | one cycle while the master lowers ready after the strobe
// SEND_LSB  | wait for ready, strobe the low byte
// ARM2      | one cycle while the master lowers ready after the strobe
// DRAIN     | wait for the frame to finish, publish dac_code, ack
// GAP       | settling time before the next grant
module dac_write_arbiter
  import dpll_pkg::*;
#(
  parameter logic [DAC_W-1:0] RESET_CODE  = RESET_CODE_DEF,
  parameter int               GAP_CYC     = 500,
  parameter int               TIMEOUT_CYC = 4096
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             loop_req,
  input  logic [DAC_W-1:0] loop_code,
  output logic             loop_ack,
  input  logic             host_req,
  input  logic [DAC_W-1:0] host_code,
  output logic             host_ack,
  input  logic             host_hold,
  output logic [7:0]       spi_tx_byte,
  output logic             spi_tx_dv,
  input  logic             spi_tx_ready,
  output logic             busy,
  output logic [DAC_W-1:0] dac_code,
  output logic             last_src,
  output logic             timeout_err,
  output logic [7:0]       drop_cnt
);

  localparam int GAP_W    = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
  localparam int GAP_LOAD = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
  localparam int TO_W     = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int TO_LAST  = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  state_t           state;
  logic [DAC_W-1:0] code;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic             grant_valid;
  logic             grant_src;
  logic             drop;
  logic [DAC_W-1:0] sel_code;
  logic [DAC_W-1:0] grant_code;
  logic             waiting;
  logic             to_expire;

  dac_rr_grant u_rr (
    .loop_req    (loop_req),
    .host_req    (host_req),
    .hold        (host_hold),
    .last_src    (last_src),
    .grant_valid (grant_valid),
    .grant_src   (grant_src),
    .drop        (drop)
  );

  assign sel_code = (grant_src == SRC_HOST) ? host_code : loop_code;

`ifdef DAC_CLAMP_EN
  assign grant_code = clamp_code(sel_code);
`else
  assign grant_code = sel_code;
`endif

  assign waiting   = (state == ST_SEND_MSB) || (state == ST_SEND_LSB) || (state == ST_DRAIN);
  assign to_expire = waiting && !spi_tx_ready && (to_cnt == TO_W'(TO_LAST));

  always_ff @(posedge clk50) begin
    if (reset) begin
      state       <= ST_IDLE;
      code        <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      loop_ack    <= 1'b0;
      host_ack    <= 1'b0;
      spi_tx_byte <= 8'h00;
      spi_tx_dv   <= 1'b0;
      busy        <= 1'b0;
      dac_code    <= RESET_CODE;
      last_src    <= SRC_LOOP;
      timeout_err <= 1'b0;
      drop_cnt    <= 8'h00;
    end else begin
      spi_tx_dv <= 1'b0;
      loop_ack  <= 1'b0;
      host_ack  <= 1'b0;
      to_cnt    <= '0;

      if (to_expire) begin
        // Abandon the frame; dac_code keeps the last code that fully landed.
        timeout_err <= 1'b1;
        if (last_src == SRC_HOST) host_ack <= 1'b1;
        else                      loop_ack <= 1'b1;
        gap_cnt <= GAP_W'(GAP_LOAD);
        state   <= ST_GAP;
      end else begin
        case (state)
          ST_IDLE: begin
            if (drop) begin
              loop_ack <= 1'b1;
              if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            if (grant_valid) begin
              code     <= grant_code;
              last_src <= grant_src;
              busy     <= 1'b1;
              state    <= ST_SEND_MSB;
            end
          end

          ST_SEND_MSB: begin
            if (spi_tx_ready) begin
              spi_tx_byte <= code[15:8];
              spi_tx_dv   <= 1'b1;
              state       <= ST_ARM1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          ST_ARM1: state <= ST_SEND_LSB;

          ST_SEND_LSB: begin
            if (spi_tx_ready) begin
              spi_tx_byte <= code[7:0];
              spi_tx_dv   <= 1'b1;
              state       <= ST_ARM2;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          ST_ARM2: state <= ST_DRAIN;

          ST_DRAIN: begin
            if (spi_tx_ready) begin
              dac_code <= code;
              if (last_src == SRC_HOST) host_ack <= 1'b1;
              else                      loop_ack <= 1'b1;
              gap_cnt <= GAP_W'(GAP_LOAD);
              state   <= ST_GAP;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          ST_GAP: begin
            if (gap_cnt == '0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end

          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dac_write_arbiter.md
Name: dac_write_arbiter

Overview:
Shares the single SPI oscillator-trim DAC between two requesters: the DPLL loop, which sends a new DAC code once per PPS, and the host, which sends manual codes through a UART register write. The block sequences each 16-bit code as a two-byte frame (MSB first) into the existing single-CS SPI master, which is configured for 2 bytes per CS frame. It also enforces a settling gap after each write and reports the last code written plus error and drop status back to the monitor register file.

Parameters:
RESET_CODE, 16'h9E23, dac_code value after reset (nominal oscillator trim)
GAP_CYC, 500, clk50 cycles of idle enforced after each completed frame before the next grant
TIMEOUT_CYC, 4096, max clk50 cycles waiting on spi_tx_ready in any state before the write is aborted
DAC_MIN, 16'h0400, lower clamp bound (used only with the optional feature)
DAC_MAX, 16'hFBFF, upper clamp bound (used only with the optional feature)

Ports:
clk50  in  1  system clock, 50 MHz
reset  in  1  synchronous reset, active-high
loop_req  in  1  loop write request; held level until loop_ack
loop_code  in  16  loop DAC code; sampled on the grant cycle
loop_ack  out  1  1-cycle pulse: loop request consumed (written, dropped or timed out)
host_req  in  1  host write request; held level until host_ack
host_code  in  16  host DAC code; sampled on the grant cycle
host_ack  out  1  1-cycle pulse: host request consumed
host_hold  in  1  host override; while 1, loop requests are consumed without writing
spi_tx_byte  out  8  byte to SPI master i_TX_Byte
spi_tx_dv  out  1  1-cycle strobe to SPI master i_TX_DV
spi_tx_ready  in  1  SPI master o_TX_Ready
busy  out  1  1 whenever state != IDLE
dac_code  out  16  last code fully shifted to the DAC
last_src  out  1  source of the last grant: 0 = loop, 1 = host
timeout_err  out  1  sticky; set on any timeout abort
drop_cnt  out  8  saturating count of loop requests dropped under host_hold

Behaviour:
- Reset state: IDLE. spi_tx_dv=0, spi_tx_byte=0, acks=0, busy=0, dac_code=RESET_CODE, last_src=0, timeout_err=0, drop_cnt=0, gap and timeout counters cleared.
- Reset asserted mid-frame: return to IDLE at once; no further dv pulses. The SPI master is not aborted, so the first grant after reset still waits for spi_tx_ready.
- All outputs are registered.
- States: IDLE -> SEND_MSB -> ARM1 -> SEND_LSB -> ARM2 -> DRAIN -> GAP -> IDLE.
- IDLE, drop path: if loop_req=1 and host_hold=1, pulse loop_ack, increment drop_cnt (saturates at 255) and stay in IDLE. This takes one cycle, and the host may be granted in the same cycle.
- IDLE, grant path, for eligible requests:
  - Only one pending: grant it.
  - Both pending: grant the source that is not last_src (round-robin).
  - On a grant, latch the code, update last_src and go to SEND_MSB.
- SEND_MSB: on the first cycle with spi_tx_ready=1, drive spi_tx_byte=code[15:8] and spi_tx_dv=1 for exactly 1 cycle, then go to ARM1.
- ARM1 / ARM2: wait exactly 1 cycle. spi_tx_ready is ignored here because the master drops ready combinationally on dv.
- SEND_LSB: same handshake as SEND_MSB with code[7:0], then go to ARM2.
- DRAIN: wait for spi_tx_ready=1 (frame done, CS released). Then:
  - dac_code <= code;
  - pulse the granted source's ack;
  - go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE. New requests stay pending during GAP. GAP_CYC=0 means 1 cycle in GAP.
- Timeout counter: runs in SEND_MSB, SEND_LSB and DRAIN; it is cleared on every state change. When it reaches TIMEOUT_CYC:
  - set timeout_err;
  - pulse the granted ack;
  - leave dac_code unchanged;
  - go to GAP.
- Latency (ready held high): grant at cycle t gives MSB dv at t+1 and LSB dv at t+3. Ack follows when the master's frame completes.
- Requester rule: req must be deasserted the cycle after ack. A req still high 1 cycle after ack is treated as a new request.
- loop_code / host_code changes after the grant have no effect on the frame in flight.

Optional Feature:
DAC_CLAMP_EN
- Defined: the latched code is clamped to [DAC_MIN, DAC_MAX] (unsigned compare) on the grant cycle; dac_code reports the clamped value.
- Undefined: the code passes through unmodified; DAC_MIN and DAC_MAX are unused.

Decomposition:
- Shared package (dpll_pkg):
  - state enum;
  - SRC_LOOP / SRC_HOST constants;
  - DAC_W=16;
  - RESET_CODE default.
- One natural sub-module: dac_rr_grant, a 2-way round-robin selector with a hold/drop input that outputs grant_valid, grant_src and drop.
- Counters and the FSM stay in the top of the block.

Test Plan:
- Single loop write, code 16'h9E30, ready model idle-high: bytes 8'h9E then 8'h30, one dv each, 2 cycles apart → loop_ack, dac_code=16'h9E30, busy low after GAP_CYC.
- loop_req and host_req in the same cycle, last_src=0: host is granted first, loop is granted after GAP; dac_code ends at loop_code, last_src=0.
- host_hold=1 with 3 loop requests: 3 loop_acks with no dv pulses, drop_cnt=3; with the counter preset near saturation, 300 loop drops leave drop_cnt=255.
- Ready held low after the MSB dv: abort at TIMEOUT_CYC, timeout_err=1, ack pulsed, dac_code unchanged; only a reset clears timeout_err.
- Reset asserted between the MSB and LSB dv: no LSB dv; dac_code=16'h9E23, all flags cleared; the next request completes normally.
- With DAC_CLAMP_EN defined, code 16'hFFFF → bytes 8'hFB, 8'hFF and dac_code=16'hFBFF; with it undefined, the bytes are 8'hFF, 8'hFF.
